capture_ctrl: RTL and testbench

Parametrised capture/readback controller for the logic analyzer core: it replaces the fixed single-mode main FSM. Samples go into a ring-buffer RAM between arm and trigger, plus a programmable post-trigger window. It then streams the newest samples back through the transmitter, newest first. Compared with the previous controller it adds:
- an explicit arm/abort,
- x4 scaled counts,
- fill tracking, so readback never returns unwritten RAM,
- busy/done status.

---
 rtl/capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_capture_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : capture_ctrl
// Purpose  : Capture/readback controller for the logic analyzer core.
//            Strobed samples are written into a ring-buffer RAM from arm
//            until trigger, then for a programmable post-trigger window.
//            The newest samples are then streamed back through the
//            transmitter, newest first. Readback is limited to the number
//            of entries actually written, so unwritten RAM is never sent.
// Ports    : clk_i, rst_in        clock, synchronous active-low reset
//            cmd_i, set_cnt_i     count register load (IDLE only)
//            arm_i, run_i         start sampling / trigger
//            abort_i              return to IDLE from any state
//            stb_i                sample valid
//            we_o, addr_o         RAM write enable / address (write or read)
//            tx_rdy_i, tx_stb_o   transmitter handshake
//            tx_sel_o             select RAM data for transmit
//            busy_o, done_o       status
// Revision : 1.0  initial release
// ============================================================================
module capture_ctrl #(
    parameter int DEPTH       = 5,
    parameter int CNT_WIDTH   = 16,
    parameter int SCALE_SHIFT = 2
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic [31:0]      cmd_i,
    input  logic             set_cnt_i,
    input  logic             arm_i,
    input  logic             run_i,
    input  logic             abort_i,
    input  logic             stb_i,
    output logic             we_o,
    output logic [DEPTH-1:0] addr_o,
    input  logic             tx_rdy_i,
    output logic             tx_stb_o,
    output logic             tx_sel_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int c_TGT_W = CNT_WIDTH + SCALE_SHIFT;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ARMED   = 3'd1;
    localparam logic [2:0] c_TRG     = 3'd2;
    localparam logic [2:0] c_TX      = 3'd3;
    localparam logic [2:0] c_TX_WAIT = 3'd4;

    // Fill saturates at exactly 2^DEPTH so a full buffer reads back every entry once.
    localparam logic [DEPTH:0] c_FILL_MAX = {1'b1, {DEPTH{1'b0}}};

    logic [2:0]           r_state;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [CNT_WIDTH-1:0] r_dly_cnt;
    logic [DEPTH-1:0]     r_wr_ptr;
    logic [DEPTH-1:0]     r_rd_ptr;
    logic [DEPTH:0]       r_fill;
    logic [c_TGT_W-1:0]   r_post_cnt;
    logic [c_TGT_W-1:0]   r_sent;
    logic [c_TGT_W-1:0]   r_n;
    logic                 r_wait_first;

    logic [c_TGT_W-1:0]   w_post_tgt;
    logic [c_TGT_W-1:0]   w_rd_tgt;
    logic [c_TGT_W-1:0]   w_fill_ext;
    logic [c_TGT_W-1:0]   w_n;
    logic                 w_post_done;
    logic                 w_tx_last;

    // Counts are in units of 2^SCALE_SHIFT samples; the widened target cannot overflow.
    assign w_post_tgt  = c_TGT_W'(r_dly_cnt) << SCALE_SHIFT;
    assign w_rd_tgt    = c_TGT_W'(r_rd_cnt) << SCALE_SHIFT;
    assign w_fill_ext  = c_TGT_W'(r_fill);
    assign w_n         = (w_rd_tgt < w_fill_ext) ? w_rd_tgt : w_fill_ext;
    assign w_post_done = (r_post_cnt == w_post_tgt);
    assign w_tx_last   = (r_sent == r_n);

    assign tx_sel_o = (r_state == c_TX) || (r_state == c_TX_WAIT);
    assign busy_o   = (r_state != c_IDLE);
    assign addr_o   = tx_sel_o ? r_rd_ptr : r_wr_ptr;

    // Strobes decoded with no added latency; abort suppresses all of them.
    always_comb begin
        we_o     = 1'b0;
        tx_stb_o = 1'b0;
        done_o   = 1'b0;
        if (!abort_i) begin
            case (r_state)
                c_ARMED: we_o = stb_i;
                c_TRG:   we_o = stb_i && !w_post_done;
                c_TX: begin
                    if (w_tx_last) begin
                        done_o = 1'b1;
                    end else begin
                        tx_stb_o = 1'b1;
                    end
                end
                default: begin
                    we_o     = 1'b0;
                    tx_stb_o = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_state      <= c_IDLE;
            r_rd_cnt     <= CNT_WIDTH'(1);
            r_dly_cnt    <= CNT_WIDTH'(1);
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_post_cnt   <= '0;
            r_sent       <= '0;
            r_n          <= '0;
            r_wait_first <= 1'b0;
        end else if (abort_i) begin
            r_state      <= c_IDLE;
            r_wait_first <= 1'b0;
        end else begin
            // Common write bookkeeping for ARMED and TRG.
            if (we_o) begin
                r_wr_ptr <= r_wr_ptr + DEPTH'(1);
                if (r_fill != c_FILL_MAX) begin
                    r_fill <= r_fill + (DEPTH+1)'(1);
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (set_cnt_i) begin
                        r_rd_cnt  <= CNT_WIDTH'({cmd_i[23:16], cmd_i[31:24]});
                        r_dly_cnt <= CNT_WIDTH'({cmd_i[7:0], cmd_i[15:8]});
                    end
                    if (arm_i) begin
                        r_state    <= c_ARMED;
                        r_wr_ptr   <= '0;
                        r_fill     <= '0;
                        r_post_cnt <= '0;
                    end
                end

                c_ARMED: begin
                    if (run_i) begin
                        r_state <= c_TRG;
                    end
                end

                c_TRG: begin
                    if (w_post_done) begin
                        // Newest sample sits just behind the write pointer.
                        r_rd_ptr <= r_wr_ptr - DEPTH'(1);
                        r_n      <= w_n;
                        r_sent   <= '0;
                        r_state  <= c_TX;
                    end else if (we_o) begin
                        r_post_cnt <= r_post_cnt + c_TGT_W'(1);
                    end
                end

                c_TX: begin
                    if (w_tx_last) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_sent       <= r_sent + c_TGT_W'(1);
                        r_wait_first <= 1'b1;
                        r_state      <= c_TX_WAIT;
                    end
                end

                c_TX_WAIT: begin
                    // The transmitter only drops ready one cycle after the
                    // strobe, so ready is not trusted in the first wait cycle.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && tx_rdy_i) begin
                        r_rd_ptr <= r_rd_ptr - DEPTH'(1);
                        r_state  <= c_TX;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_ctrl
// Purpose  : Self-checking bench for capture_ctrl. A monitor records every
//            RAM write and transmit strobe; each capture is checked against
//            expectations derived from the buffer semantics (write k lands at
//            k mod 2^DEPTH, readback is the newest min(rd,fill) entries in
//            reverse order), plus directed cases for backpressure, abort,
//            reset and configuration guarding.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_capture_ctrl;

    localparam int DEPTH       = 5;
    localparam int CNT_WIDTH   = 16;
    localparam int SCALE_SHIFT = 2;
    localparam int SIZE        = 1 << DEPTH;

    logic             clk_i = 1'b0;
    logic             rst_in;
    logic [31:0]      cmd_i;
    logic             set_cnt_i;
    logic             arm_i;
    logic             run_i;
    logic             abort_i;
    logic             stb_i;
    logic             we_o;
    logic [DEPTH-1:0] addr_o;
    logic             tx_rdy_i;
    logic             tx_stb_o;
    logic             tx_sel_o;
    logic             busy_o;
    logic             done_o;

    always #5 clk_i = ~clk_i;

    capture_ctrl #(
        .DEPTH       (DEPTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .cmd_i     (cmd_i),
        .set_cnt_i (set_cnt_i),
        .arm_i     (arm_i),
        .run_i     (run_i),
        .abort_i   (abort_i),
        .stb_i     (stb_i),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .tx_rdy_i  (tx_rdy_i),
        .tx_stb_o  (tx_stb_o),
        .tx_sel_o  (tx_sel_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference configuration as the bench believes it is loaded.
    int m_rd  = 1;
    int m_dly = 1;

    // Monitor state: append-only logs, read only after the next posedge.
    int   wr_q[$];
    int   tx_q[$];
    int   tx_cyc_q[$];
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   done_busy = 0;
    int   fall_cyc  = 0;
    int   cyc       = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (rst_in) begin
            if (we_o) wr_q.push_back(int'(addr_o));
            if (tx_stb_o) begin
                tx_q.push_back(int'(addr_o));
                tx_cyc_q.push_back(cyc);
            end
            if (done_o) begin
                done_cnt  = done_cnt + 1;
                done_cyc  = cyc;
                done_busy = int'(busy_o);
            end
            if (prev_busy && !busy_o) fall_cyc = cyc;
        end
        prev_busy = busy_o;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input int rd, input int dly);
        logic [15:0] r16;
        logic [15:0] d16;
        r16       = 16'(rd);
        d16       = 16'(dly);
        cmd_i     = {r16[7:0], r16[15:8], d16[7:0], d16[15:8]};
        set_cnt_i = 1'b1;
        tick();
        set_cnt_i = 1'b0;
        m_rd      = rd;
        m_dly     = dly;
    endtask

    // Drives random strobes/ready until the controller returns to IDLE.
    task automatic wait_idle(input string tag, input int rdy_pct);
        bit idle = 1'b0;
        for (int i = 0; i < 4000 && !idle; i++) begin
            stb_i    = 1'($urandom_range(0, 1));
            tx_rdy_i = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk_i);
            if (!busy_o) idle = 1'b1;
            tick();
        end
        stb_i = 1'b0;
        check({tag, " reach idle"}, int'(idle), 1);
    endtask

    // Returns at the negedge of the strobe cycle when a strobe is seen.
    task automatic wait_tx(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (tx_stb_o) seen = 1'b1;
            else tick();
        end
        check({tag, " tx strobe seen"}, int'(seen), 1);
    endtask

    task automatic load_samples(input int pre);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        repeat (pre) begin
            stb_i = 1'b1;
            tick();
        end
        stb_i = 1'b0;
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    // One full capture with random gaps, checked against the buffer model.
    task automatic capture(input int pre, input int rdy_pct, input bit guard, input string name);
        int wr_base;
        int tx_base;
        int done_base;
        int given;
        int post_given;
        int tgt;
        int total;
        int fill;
        int n;
        int nw;
        int nt;
        wr_base   = wr_q.size();
        tx_base   = tx_q.size();
        done_base = done_cnt;

        // Arm cycle: run and stb are ignored while still in IDLE.
        arm_i = 1'b1;
        run_i = 1'($urandom_range(0, 1));
        stb_i = 1'($urandom_range(0, 1));
        tick();
        arm_i = 1'b0;
        run_i = 1'b0;

        given = 0;
        while (given < pre) begin
            stb_i = ($urandom_range(0, 3) != 0);
            if (stb_i) given++;
            tick();
        end
        // A strobe in the trigger cycle still counts as pre-trigger.
        run_i = 1'b1;
        stb_i = 1'($urandom_range(0, 1));
        if (stb_i) given++;
        tick();
        run_i = 1'b0;

        tgt        = m_dly << SCALE_SHIFT;
        post_given = 0;
        while (post_given < tgt) begin
            stb_i = ($urandom_range(0, 2) != 0);
            if (stb_i) post_given++;
            if (guard) begin
                set_cnt_i = 1'($urandom_range(0, 1));
                cmd_i     = $urandom;
            end
            tick();
        end
        set_cnt_i = 1'b0;

        wait_idle(name, rdy_pct);

        total = given + tgt;
        fill  = (total < SIZE) ? total : SIZE;
        n     = ((m_rd << SCALE_SHIFT) < fill) ? (m_rd << SCALE_SHIFT) : fill;

        nw = wr_q.size() - wr_base;
        nt = tx_q.size() - tx_base;
        check({name, " write count"}, nw, total);
        for (int k = 0; k < nw && k < total; k++)
            check({name, " write addr"}, wr_q[wr_base + k], k % SIZE);
        check({name, " tx count"}, nt, n);
        for (int j = 0; j < nt && j < n; j++)
            check({name, " tx addr"}, tx_q[tx_base + j], (total - 1 - j) % SIZE);
        for (int j = 1; j < nt; j++)
            check({name, " tx spacing>=3"},
                  int'(tx_cyc_q[tx_base + j] - tx_cyc_q[tx_base + j - 1] >= 3), 1);
        check({name, " done count"}, done_cnt - done_base, 1);
        check({name, " busy at done"}, done_busy, 1);
        check({name, " busy falls after done"}, fall_cyc - done_cyc, 1);
        if (nt > 0)
            check({name, " done after last tx"},
                  int'(done_cyc - tx_cyc_q[tx_base + nt - 1] >= 3), 1);
    endtask

    task automatic idle_gap(input int cycles);
        int wr_base;
        int tx_base;
        int done_base;
        wr_base   = wr_q.size();
        tx_base   = tx_q.size();
        done_base = done_cnt;
        repeat (cycles) begin
            stb_i    = 1'($urandom_range(0, 1));
            run_i    = 1'($urandom_range(0, 1));
            tx_rdy_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            check("idle busy", int'(busy_o), 0);
            tick();
        end
        stb_i = 1'b0;
        run_i = 1'b0;
        check("idle writes", wr_q.size() - wr_base, 0);
        check("idle tx/done", (tx_q.size() - tx_base) + (done_cnt - done_base), 0);
    endtask

    initial begin
        int tx_base;
        int done_base;
        rst_in    = 1'b0;
        cmd_i     = '0;
        set_cnt_i = 1'b0;
        arm_i     = 1'b0;
        run_i     = 1'b0;
        abort_i   = 1'b0;
        stb_i     = 1'b0;
        tx_rdy_i  = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk_i);
        check("rst we_o", int'(we_o), 0);
        check("rst addr_o", int'(addr_o), 0);
        check("rst tx_stb_o", int'(tx_stb_o), 0);
        check("rst tx_sel_o", int'(tx_sel_o), 0);
        check("rst busy_o", int'(busy_o), 0);
        check("rst done_o", int'(done_o), 0);
        rst_in = 1'b1;
        tick();

        // Defaults rd=dly=1: 4 post writes, 4 readbacks
        capture(10, 100, 1'b0, "dflt");
        idle_gap(3);

        // Wrap and clamp: rd=16, dly=0, more samples than the buffer holds
        set_cfg(16, 0);
        capture(40, 100, 1'b0, "wrap");

        // Under-fill: fewer samples than requested
        set_cfg(4, 0);
        capture(5, 70, 1'b0, "under");

        // Backpressure: ready held low in TX_WAIT
        set_cfg(1, 0);
        tx_base   = tx_q.size();
        done_base = done_cnt;
        tx_rdy_i  = 1'b0;
        load_samples(3);
        wait_tx("bp");
        check("bp first addr", int'(addr_o), 2);
        tick();
        repeat (20) begin
            @(negedge clk_i);
            check("bp no strobe", int'(tx_stb_o), 0);
            check("bp tx_sel", int'(tx_sel_o), 1);
            check("bp addr stable", int'(addr_o), 2);
            tick();
        end
        wait_idle("bp", 100);
        check("bp tx count", tx_q.size() - tx_base, 3);
        for (int j = 0; j < 3 && tx_base + j < tx_q.size(); j++)
            check("bp tx addr", tx_q[tx_base + j], 2 - j);
        check("bp done count", done_cnt - done_base, 1);

        // Abort in TX_WAIT
        set_cfg(2, 0);
        done_base = done_cnt;
        tx_rdy_i  = 1'b0;
        load_samples(6);
        wait_tx("abort_tx");
        tick();
        abort_i  = 1'b1;
        tx_rdy_i = 1'b1;
        @(negedge clk_i);
        check("abort_tx strobe", int'(tx_stb_o), 0);
        check("abort_tx done", int'(done_o), 0);
        tick();
        abort_i = 1'b0;
        @(negedge clk_i);
        check("abort_tx busy", int'(busy_o), 0);
        check("abort_tx tx_sel", int'(tx_sel_o), 0);
        tick();
        tx_base = tx_q.size();
        repeat (10) tick();
        check("abort_tx later strobes", tx_q.size() - tx_base, 0);
        check("abort_tx no done", done_cnt - done_base, 0);

        // Abort together with a strobe in ARMED
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        stb_i = 1'b1;
        tick();
        abort_i = 1'b1;
        @(negedge clk_i);
        check("abort_armed we_o", int'(we_o), 0);
        tick();
        abort_i = 1'b0;
        stb_i   = 1'b0;
        @(negedge clk_i);
        check("abort_armed busy", int'(busy_o), 0);
        tick();

        // Config guard: set_cnt during TRG is ignored, later IDLE load applies
        set_cfg(1, 2);
        capture(8, 60, 1'b1, "guard");
        set_cfg(2, 1);
        capture(12, 60, 1'b0, "newcfg");

        // Reset mid-operation restores power-on state including counts
        set_cfg(3, 3);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        stb_i = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        @(negedge clk_i);
        check("midrst busy", int'(busy_o), 0);
        check("midrst we_o", int'(we_o), 0);
        check("midrst addr", int'(addr_o), 0);
        check("midrst tx_sel", int'(tx_sel_o), 0);
        tick();
        stb_i = 1'b0;
        m_rd  = 1;
        m_dly = 1;
        capture(10, 80, 1'b0, "post_rst");

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            bit g;
            if ($urandom_range(0, 2) != 0)
                set_cfg(int'($urandom_range(0, 10)), int'($urandom_range(0, 5)));
            g = (m_dly > 0) && ($urandom_range(0, 1) != 0);
            capture(int'($urandom_range(0, 45)), int'($urandom_range(20, 100)), g, "rand");
            idle_gap(int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
